// File: rtl/packet_receiver.sv
// packet_receiver
// Host-command parser sitting between the proto245 FIFO bridge and the
// phase, calibration and modulation logic. Frames are
//   0xAA, code, DATA_BYTES payload (LSB first), [XOR checksum], 0x55.
// Valid frames update latest_data and trigger one action per code:
//   0x01 phase parse pulse, 0x02 burst streaming, 0x03 calibration pulse,
//   0x04 modulation settings, 0x05 status reply on the TX FIFO.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   rxfifo_*          RX byte source; rxfifo_rd is the read/accept strobe
//   txfifo_*          TX byte sink for status replies
//   latest_data       payload of the last valid frame
//   phase_parse_en    pulse on a valid 0x01 frame
//   phase_calib_en    pulse on a valid 0x03 frame
//   mod_enable        modulation enable (payload[0] of a 0x04 frame)
//   mod_set           per-channel load strobe (payload[24 +: MOD_CHANNELS])
//   mod_half_period   modulation half period (payload[16:1])
//   burst_data/valid  burst byte stream, burst_ready applies backpressure
//   read_error        sticky error flag
//   err_count         saturating error counter
module packet_receiver #(
  parameter int TX_FIFO_LOAD_W = 13,
  parameter int RX_FIFO_LOAD_W = 13,
  parameter int MOD_CHANNELS   = 4,
  parameter int DATA_BYTES     = 4,
  parameter int CHECKSUM_EN    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rxfifo_data,
  input  logic                      rxfifo_valid,
  input  logic [RX_FIFO_LOAD_W-1:0] rxfifo_load,
  input  logic                      rxfifo_empty,
  output logic                      rxfifo_rd,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  input  logic                      txfifo_full,
  output logic                      txfifo_wr,
  output logic [7:0]                txfifo_data,
  output logic [8*DATA_BYTES-1:0]   latest_data,
  output logic                      phase_parse_en,
  output logic                      phase_calib_en,
  output logic                      mod_enable,
  output logic [MOD_CHANNELS-1:0]   mod_set,
  output logic [15:0]               mod_half_period,
  output logic [7:0]                burst_data,
  output logic                      burst_valid,
  input  logic                      burst_ready,
  output logic                      read_error,
  output logic [7:0]                err_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CODE   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_SUFFIX = 3'd4;
  localparam logic [2:0] S_BURST  = 3'd5;
  localparam logic [2:0] S_REPLY  = 3'd6;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]              state;
  logic [2:0]              byte_idx;
  logic [7:0]              code_reg;
  logic [7:0]              csum_acc;
  logic [8*DATA_BYTES-1:0] data_buf;
  logic [15:0]             burst_cnt;
  logic [TO_W-1:0]         idle_cnt;
  logic [2:0]              reply_idx;
  logic [7:0]              snap_err;
  logic [7:0]              snap_frames;
  logic [7:0]              frame_cnt;

  logic accepting;
  logic take;
  logic timeout_tick;
  logic timeout_hit;
  logic csum_bad;
  logic suffix_bad;
  logic code_bad;
  logic any_err;
  logic unused_inputs;

  // FIFO load fields are carried for interface compatibility only.
  assign unused_inputs = ^{rxfifo_load, txfifo_load};

  always_comb begin
    accepting = 1'b0;
    case (state)
      S_IDLE, S_CODE, S_DATA, S_CSUM, S_SUFFIX: accepting = 1'b1;
      S_BURST:                                  accepting = burst_ready;
      default:                                  accepting = 1'b0;
    endcase
  end

  // Strobes are gated by rst so nothing leaks out while reset is held.
  assign rxfifo_rd   = !rst && !rxfifo_empty && accepting;
  assign take        = rxfifo_rd && rxfifo_valid;
  assign burst_valid = take && (state == S_BURST);
  assign burst_data  = burst_valid ? rxfifo_data : 8'h00;
  assign txfifo_wr   = !rst && (state == S_REPLY) && !txfifo_full;

  always_comb begin
    txfifo_data = 8'h00;
    if (!rst && state == S_REPLY) begin
      case (reply_idx)
        3'd0:    txfifo_data = 8'hAA;
        3'd1:    txfifo_data = 8'h85;
        3'd2:    txfifo_data = snap_err;
        3'd3:    txfifo_data = snap_frames;
        3'd4:    txfifo_data = 8'h55;
        default: txfifo_data = 8'h00;
      endcase
    end
  end

  // Backpressured burst cycles neither count toward nor clear the timeout.
  always_comb begin
    timeout_tick = 1'b0;
    if (!take) begin
      if (state == S_CODE || state == S_DATA || state == S_CSUM || state == S_SUFFIX)
        timeout_tick = 1'b1;
      else if (state == S_BURST && burst_ready)
        timeout_tick = 1'b1;
    end
  end

  assign timeout_hit = timeout_tick && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign csum_bad    = (state == S_CSUM) && take && (rxfifo_data != csum_acc);
  assign suffix_bad  = (state == S_SUFFIX) && take && (rxfifo_data != 8'h55);
  assign code_bad    = (state == S_SUFFIX) && take && (rxfifo_data == 8'h55) &&
                       !(code_reg >= 8'h01 && code_reg <= 8'h05);
  assign any_err     = csum_bad || suffix_bad || code_bad || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      byte_idx        <= '0;
      code_reg        <= '0;
      csum_acc        <= '0;
      data_buf        <= '0;
      burst_cnt       <= '0;
      idle_cnt        <= '0;
      reply_idx       <= '0;
      snap_err        <= '0;
      snap_frames     <= '0;
      frame_cnt       <= '0;
      latest_data     <= '0;
      phase_parse_en  <= 1'b0;
      phase_calib_en  <= 1'b0;
      mod_enable      <= 1'b0;
      mod_set         <= '0;
      mod_half_period <= '0;
      read_error      <= 1'b0;
      err_count       <= '0;
    end else begin
      phase_parse_en <= 1'b0;
      phase_calib_en <= 1'b0;
      mod_set        <= '0;

      if (take || state == S_IDLE || state == S_REPLY || timeout_hit)
        idle_cnt <= '0;
      else if (timeout_tick)
        idle_cnt <= idle_cnt + 1'b1;

      if (any_err) begin
        // The offending byte is consumed here, so it is never re-read as a prefix.
        read_error <= 1'b1;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (take && rxfifo_data == 8'hAA)
              state <= S_CODE;
          end
          S_CODE: begin
            if (take) begin
              code_reg <= rxfifo_data;
              csum_acc <= rxfifo_data;
              byte_idx <= '0;
              state    <= S_DATA;
            end
          end
          S_DATA: begin
            if (take) begin
              data_buf[8*byte_idx +: 8] <= rxfifo_data;
              csum_acc                  <= csum_acc ^ rxfifo_data;
              if (byte_idx == 3'(DATA_BYTES - 1))
                state <= (CHECKSUM_EN != 0) ? S_CSUM : S_SUFFIX;
              else
                byte_idx <= byte_idx + 3'd1;
            end
          end
          S_CSUM: begin
            if (take)
              state <= S_SUFFIX;
          end
          S_SUFFIX: begin
            // Commit: outputs registered here become visible the next cycle.
            if (take) begin
              latest_data <= data_buf;
              frame_cnt   <= frame_cnt + 8'd1;
              state       <= S_IDLE;
              case (code_reg)
                8'h01: phase_parse_en <= 1'b1;
                8'h02: begin
                  burst_cnt <= data_buf[15:0];
                  if (data_buf[15:0] != 16'd0)
                    state <= S_BURST;
                end
                8'h03: phase_calib_en <= 1'b1;
                8'h04: begin
                  mod_enable      <= data_buf[0];
                  mod_half_period <= data_buf[16:1];
                  mod_set         <= data_buf[24 +: MOD_CHANNELS];
                end
                default: begin
                  // Only 0x05 reaches here; unknown codes are caught by code_bad.
                  snap_err    <= err_count;
                  snap_frames <= frame_cnt + 8'd1;
                  reply_idx   <= '0;
                  state       <= S_REPLY;
                end
              endcase
            end
          end
          S_BURST: begin
            if (take) begin
              burst_cnt <= burst_cnt - 16'd1;
              if (burst_cnt == 16'd1)
                state <= S_IDLE;
            end
          end
          S_REPLY: begin
            if (txfifo_wr) begin
              if (reply_idx == 3'd4)
                state <= S_IDLE;
              else
                reply_idx <= reply_idx + 3'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver
// Directed bench for packet_receiver with default parameters. A byte queue
// models the RX FIFO; burst beats, TX writes and strobes are collected once
// per cycle and compared against hand-computed values.
module tb_packet_receiver;

  localparam int DATA_BYTES     = 4;
  localparam int MOD_CHANNELS   = 4;
  localparam int TIMEOUT_CYCLES = 1024;

  logic                      clk;
  logic                      rst;
  logic [7:0]                rxfifo_data;
  logic                      rxfifo_valid;
  logic [12:0]               rxfifo_load;
  logic                      rxfifo_empty;
  logic                      rxfifo_rd;
  logic [12:0]               txfifo_load;
  logic                      txfifo_full;
  logic                      txfifo_wr;
  logic [7:0]                txfifo_data;
  logic [8*DATA_BYTES-1:0]   latest_data;
  logic                      phase_parse_en;
  logic                      phase_calib_en;
  logic                      mod_enable;
  logic [MOD_CHANNELS-1:0]   mod_set;
  logic [15:0]               mod_half_period;
  logic [7:0]                burst_data;
  logic                      burst_valid;
  logic                      burst_ready;
  logic                      read_error;
  logic [7:0]                err_count;

  packet_receiver #(
    .TX_FIFO_LOAD_W(13),
    .RX_FIFO_LOAD_W(13),
    .MOD_CHANNELS(MOD_CHANNELS),
    .DATA_BYTES(DATA_BYTES),
    .CHECKSUM_EN(1),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxfifo_data(rxfifo_data),
    .rxfifo_valid(rxfifo_valid),
    .rxfifo_load(rxfifo_load),
    .rxfifo_empty(rxfifo_empty),
    .rxfifo_rd(rxfifo_rd),
    .txfifo_load(txfifo_load),
    .txfifo_full(txfifo_full),
    .txfifo_wr(txfifo_wr),
    .txfifo_data(txfifo_data),
    .latest_data(latest_data),
    .phase_parse_en(phase_parse_en),
    .phase_calib_en(phase_calib_en),
    .mod_enable(mod_enable),
    .mod_set(mod_set),
    .mod_half_period(mod_half_period),
    .burst_data(burst_data),
    .burst_valid(burst_valid),
    .burst_ready(burst_ready),
    .read_error(read_error),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] beats[$];
  logic [7:0] tx_bytes[$];
  int         parse_cnt;
  int         calib_cnt;
  int         modset_cnt;
  logic [7:0] last_modset;
  int         wr_while_full;
  bit         toggle_ready;
  bit         arm_full;
  int         full_cd;
  int         checks;
  int         errors;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One call = n clock cycles: drive at negedge, sample #1 later, pop on the posedge.
  task automatic applyStimulus(input int n);
    logic take;
    for (int i = 0; i < n; i++) begin
      rxfifo_empty = (rx_q.size() == 0);
      rxfifo_valid = !rxfifo_empty;
      rxfifo_data  = rxfifo_empty ? 8'h00 : rx_q[0];
      burst_ready  = toggle_ready ? !burst_ready : 1'b1;
      txfifo_full  = (full_cd > 0);
      if (full_cd > 0) full_cd--;
      #1;
      take = rxfifo_rd && rxfifo_valid;
      if (phase_parse_en) parse_cnt++;
      if (phase_calib_en) calib_cnt++;
      if (mod_set != '0) begin
        modset_cnt++;
        last_modset = 8'(mod_set);
      end
      if (burst_valid) beats.push_back(burst_data);
      if (txfifo_wr) begin
        tx_bytes.push_back(txfifo_data);
        if (txfifo_full) wr_while_full++;
      end
      if (arm_full && tx_bytes.size() == 2) begin
        full_cd  = 3;
        arm_full = 1'b0;
      end
      @(posedge clk);
      if (take) void'(rx_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic clear_monitors();
    parse_cnt     = 0;
    calib_cnt     = 0;
    modset_cnt    = 0;
    last_modset   = 8'h00;
    wr_while_full = 0;
    beats.delete();
    tx_bytes.delete();
  endtask

  task automatic push_frame(input logic [7:0] code, input logic [31:0] payload,
                            input logic [7:0] csum, input logic [7:0] suffix);
    rx_q.push_back(8'hAA);
    rx_q.push_back(code);
    for (int b = 0; b < 4; b++) rx_q.push_back(payload[8*b +: 8]);
    rx_q.push_back(csum);
    rx_q.push_back(suffix);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(2);
    rx_q.delete();
    rst = 1'b0;
    applyStimulus(1);
    clear_monitors();
  endtask

  logic [7:0] reply_exp[5];

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    rxfifo_data  = 8'h00;
    rxfifo_valid = 1'b0;
    rxfifo_empty = 1'b1;
    rxfifo_load  = '0;
    txfifo_load  = '0;
    txfifo_full  = 1'b0;
    burst_ready  = 1'b1;
    toggle_ready = 1'b0;
    arm_full     = 1'b0;
    full_cd      = 0;
    clear_monitors();
    @(negedge clk);
    do_reset();

    checkOutput("reset_latest", 64'(latest_data), 64'h0);
    checkOutput("reset_read_error", 64'(read_error), 64'h0);
    checkOutput("reset_err_count", 64'(err_count), 64'h0);
    checkOutput("reset_rxfifo_rd", 64'(rxfifo_rd), 64'h0);
    checkOutput("reset_txfifo_wr", 64'(txfifo_wr), 64'h0);
    checkOutput("reset_mod_half", 64'(mod_half_period), 64'h0);

    // Phase parse frame
    push_frame(8'h01, 32'h00010123, 8'h22, 8'h55);
    applyStimulus(12);
    checkOutput("p01_latest", 64'(latest_data), 64'h00010123);
    checkOutput("p01_parse_pulses", 64'(parse_cnt), 64'd1);
    checkOutput("p01_read_error", 64'(read_error), 64'h0);

    // Modulation frame
    clear_monitors();
    push_frame(8'h04, 32'h0F00000B, 8'h00, 8'h55);
    applyStimulus(12);
    checkOutput("mod_enable", 64'(mod_enable), 64'h1);
    checkOutput("mod_half_period", 64'(mod_half_period), 64'd5);
    checkOutput("mod_set_pulses", 64'(modset_cnt), 64'd1);
    checkOutput("mod_set_value", 64'(last_modset), 64'h0F);
    checkOutput("mod_latest", 64'(latest_data), 64'h0F00000B);

    // Calibration frame (third valid frame)
    clear_monitors();
    push_frame(8'h03, 32'h00000000, 8'h03, 8'h55);
    applyStimulus(12);
    checkOutput("calib_pulses", 64'(calib_cnt), 64'd1);
    checkOutput("calib_latest", 64'(latest_data), 64'h0);

    // Status reply with TX FIFO full for 3 cycles after the second byte
    clear_monitors();
    arm_full = 1'b1;
    push_frame(8'h05, 32'h00000000, 8'h05, 8'h55);
    applyStimulus(20);
    reply_exp = '{8'hAA, 8'h85, 8'h00, 8'h04, 8'h55};
    checkOutput("reply_len", 64'(tx_bytes.size()), 64'd5);
    for (int i = 0; i < 5 && i < tx_bytes.size(); i++)
      checkOutput($sformatf("reply_byte%0d", i), 64'(tx_bytes[i]), 64'(reply_exp[i]));
    checkOutput("reply_wr_while_full", 64'(wr_while_full), 64'd0);

    // Burst of 16 bytes with backpressure toggling every cycle
    clear_monitors();
    push_frame(8'h02, 32'h00000010, 8'h12, 8'h55);
    for (int i = 0; i < 16; i++) rx_q.push_back(8'(i));
    toggle_ready = 1'b1;
    applyStimulus(60);
    toggle_ready = 1'b0;
    checkOutput("burst_beats", 64'(beats.size()), 64'd16);
    for (int i = 0; i < 16 && i < beats.size(); i++)
      checkOutput($sformatf("burst_byte%0d", i), 64'(beats[i]), 64'(i));
    push_frame(8'h01, 32'h00010123, 8'h22, 8'h55);
    applyStimulus(12);
    checkOutput("post_burst_parse", 64'(parse_cnt), 64'd1);
    checkOutput("post_burst_no_extra", 64'(beats.size()), 64'd16);

    // Bad checksum then bad suffix, then a valid calibration frame
    clear_monitors();
    push_frame(8'h01, 32'h00000000, 8'hFF, 8'h55);
    push_frame(8'h01, 32'h00000000, 8'h01, 8'h56);
    applyStimulus(25);
    checkOutput("err_no_parse", 64'(parse_cnt), 64'd0);
    checkOutput("err_count_2", 64'(err_count), 64'd2);
    checkOutput("err_read_error", 64'(read_error), 64'h1);
    push_frame(8'h03, 32'h00000000, 8'h03, 8'h55);
    applyStimulus(12);
    checkOutput("err_then_calib", 64'(calib_cnt), 64'd1);
    checkOutput("err_count_kept", 64'(err_count), 64'd2);

    // Inter-byte timeout
    do_reset();
    rx_q.push_back(8'hAA);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h23);
    applyStimulus(3 + 1000);
    checkOutput("timeout_not_yet", 64'(err_count), 64'd0);
    applyStimulus(30);
    checkOutput("timeout_err_count", 64'(err_count), 64'd1);
    checkOutput("timeout_read_error", 64'(read_error), 64'h1);
    push_frame(8'h01, 32'h00010123, 8'h22, 8'h55);
    applyStimulus(12);
    checkOutput("timeout_then_parse", 64'(parse_cnt), 64'd1);

    // Reset in the middle of a burst
    do_reset();
    push_frame(8'h02, 32'h00000010, 8'h12, 8'h55);
    for (int i = 0; i < 16; i++) rx_q.push_back(8'(i));
    applyStimulus(13);
    checkOutput("midburst_beats", 64'(beats.size()), 64'd5);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_rxfifo_rd", 64'(rxfifo_rd), 64'h0);
    checkOutput("rst_burst_valid", 64'(burst_valid), 64'h0);
    checkOutput("rst_burst_data", 64'(burst_data), 64'h0);
    applyStimulus(1);
    rx_q.delete();
    rst = 1'b0;
    clear_monitors();
    applyStimulus(1);
    checkOutput("after_rst_latest", 64'(latest_data), 64'h0);
    checkOutput("after_rst_burst_valid", 64'(burst_valid), 64'h0);
    checkOutput("after_rst_err_count", 64'(err_count), 64'h0);
    checkOutput("after_rst_strobes", 64'(parse_cnt + calib_cnt + modset_cnt), 64'd0);
    push_frame(8'h01, 32'h11223344, 8'h45, 8'h55);
    applyStimulus(12);
    checkOutput("after_rst_frame_latest", 64'(latest_data), 64'h11223344);
    checkOutput("after_rst_frame_parse", 64'(parse_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Host-command parser between the proto245 FIFO bridge and the phase, calibration and modulation logic.
- Parametrised successor of the fixed 8-byte command receiver. Adds:
  - configurable payload width;
  - configurable modulation channel count;
  - optional XOR checksum;
  - inter-byte timeout;
  - burst streaming with backpressure;
  - status-reply frames on the TX FIFO.

Parameters:
- TX_FIFO_LOAD_W, 13, width of the TX FIFO load field; informational only.
- RX_FIFO_LOAD_W, 13, width of the RX FIFO load field; informational only.
- MOD_CHANNELS, 4, number of modulation channels; range 1-8.
- DATA_BYTES, 4, payload bytes per frame; range 4-8.
- CHECKSUM_EN, 1, when 1 an XOR checksum byte follows the payload.
- TIMEOUT_CYCLES, 1024, idle cycles allowed mid-frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rxfifo_data  in  8  RX byte.
- rxfifo_valid  in  1  rxfifo_data is valid.
- rxfifo_load  in  RX_FIFO_LOAD_W  RX FIFO occupancy; unused.
- rxfifo_empty  in  1  RX FIFO empty.
- rxfifo_rd  out  1  read strobe / accept.
- txfifo_load  in  TX_FIFO_LOAD_W  TX FIFO occupancy; unused.
- txfifo_full  in  1  TX FIFO full.
- txfifo_wr  out  1  TX write strobe.
- txfifo_data  out  8  TX byte.
- latest_data  out  8*DATA_BYTES  payload of the last valid frame.
- phase_parse_en  out  1  one-cycle pulse on a valid code 0x01 frame.
- phase_calib_en  out  1  one-cycle pulse on a valid code 0x03 frame.
- mod_enable  out  1  modulation enable.
- mod_set  out  MOD_CHANNELS  one-cycle per-channel load strobe.
- mod_half_period  out  16  modulation half period.
- burst_data  out  8  burst byte.
- burst_valid  out  1  burst byte valid.
- burst_ready  in  1  sink accepts the burst byte.
- read_error  out  1  sticky error flag; cleared only by reset.
- err_count  out  8  saturating error counter.

Behaviour:
- Byte handshake: a byte is consumed on any cycle with rxfifo_rd && rxfifo_valid. rxfifo_rd = !rxfifo_empty && state accepts input.
  - Accepting states: IDLE, CODE, DATA, CSUM, SUFFIX.
  - BURST accepts input only while burst_ready is high.
  - REPLY never accepts input.
- Frame format, in order:
  - 0xAA prefix;
  - code byte;
  - DATA_BYTES payload bytes, little-endian, first byte is bits [7:0];
  - checksum byte when CHECKSUM_EN, equal to the XOR of the code and payload bytes;
  - 0x55 suffix.
- States: IDLE, CODE, DATA, CSUM, SUFFIX, BURST, REPLY.
  - IDLE: any byte other than 0xAA is discarded silently.
  - DATA: a byte counter runs 0..DATA_BYTES-1.
  - CSUM: a mismatch is an error.
  - SUFFIX: any byte other than 0x55 is an error; the frame is dropped.
- Frame commit happens on the cycle after the suffix byte is consumed. latest_data updates and the selected action fires in that cycle:
  - 0x01: phase_parse_en pulses.
  - 0x02: enter BURST with count = payload[15:0].
  - 0x03: phase_calib_en pulses.
  - 0x04: mod_enable = payload[0], mod_half_period = payload[16:1], mod_set = payload[24 +: MOD_CHANNELS] pulsed for one cycle.
  - 0x05: enter REPLY.
  - Any other code: error; no output changes; latest_data is not updated.
- BURST:
  - Each consumed byte drives burst_data, with burst_valid high in the same cycle (combinational pass-through of the byte handshake).
  - The remaining count decrements per byte; the state returns to IDLE when it reaches 0.
  - A count of 0 returns to IDLE immediately.
  - The timeout applies in BURST.
- REPLY: emits 5 bytes: 0xAA, 0x85, err_count, count of valid frames mod 256, 0x55.
  - One byte is written per cycle while !txfifo_full.
  - txfifo_wr stays low while txfifo_full; the byte index holds.
  - err_count and the frame count are snapshotted at REPLY entry.
- Timeout: in any state other than IDLE or REPLY, TIMEOUT_CYCLES consecutive cycles with no byte consumed raise an error and force IDLE.
  - In BURST, cycles with burst_ready low do not count.
- Error handling: read_error is set to 1. err_count increments and saturates at 255. The state returns to IDLE; a byte that caused the error is not reinterpreted as a prefix.
- Reset values: all outputs 0, except mod_half_period = 0 and rxfifo_rd = 0. State resets to IDLE and all counters clear.
- Reset mid-frame or mid-burst: the partial frame is discarded; no strobes fire on the cycle reset deasserts.
- Empty FIFO mid-frame: the state holds; only the timeout advances.

Test Plan:
- Default parameters, frame AA 01 23 01 01 00 csum=0x22 55 -> latest_data=0x00010123, phase_parse_en high for exactly 1 cycle, read_error=0.
- Frame AA 04, payload 0x0F00000B (bytes 0B 00 00 0F), valid csum, 55 -> mod_enable=1, mod_half_period=5, mod_set=4'b1111 pulsed 1 cycle.
- Frame AA 02 payload 0x00000010, then bytes 0x00..0x0F with burst_ready toggled every other cycle -> 16 burst_valid beats carrying 0..15 in order, no byte lost or duplicated, state IDLE afterwards.
- Bad checksum frame, then a frame with 0x56 as suffix -> no strobes, err_count=2, read_error=1. A following valid 0x03 frame -> phase_calib_en pulses.
- Three valid frames, then AA 05 frame while txfifo_full is high for 3 cycles mid-reply -> TX sees AA 85 00 04 55 exactly once, with no writes while full. The frame count is 4 because it includes the 0x05 frame.
- Prefix plus 2 bytes, then rxfifo_empty held for TIMEOUT_CYCLES -> err_count=1 and IDLE. Separately, rst asserted mid-burst -> all outputs 0, and the next AA frame parses normally.
